instr_phase_sequencer: RTL and testbench

Multi-cycle control sequencer for the board CPU core. It steps each instruction through four phases: FETCH, DECODE, EXEC and WB. Without a stall, each instruction takes exactly 4 clocks. EXEC can be held by a datapath stall (memory or UART wait), and the block handles run/halt control, retired-instruction counting and a stall watchdog.

---
 rtl/instr_phase_sequencer.sv | 121 ++++++++++++
 tb/tb_instr_phase_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_phase_sequencer.sv
// Multi-cycle instruction phase sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> WB, with EXEC stall hold, run/halt control,
// a retired-instruction counter and a stall watchdog.
//
// Ports:
//   clk           rising-edge system clock
//   rst_n         synchronous active-low reset
//   run           level; lets a new instruction start from IDLE / after WB
//   halt_req      level; stop at the next instruction boundary
//   stall         datapath busy, only looked at while in EXEC
//   resume        pulse; leaves HALTED or ERROR back to IDLE
//   ph_fetch/ph_decode/ph_exec/ph_wb  one-hot phase indicators
//   instr_done    one-cycle pulse in the cycle after WB
//   retired_count completed instructions, wraps modulo 2^CNT_W
//   halted        high while in HALTED
//   stall_timeout high while in ERROR
module instr_phase_sequencer #(
  parameter int unsigned PHASES_PER_INSTR = 4,
  parameter int unsigned STALL_TIMEOUT    = 64,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             resume,
  output logic             ph_fetch,
  output logic             ph_decode,
  output logic             ph_exec,
  output logic             ph_wb,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic             stall_timeout
);

  // Counter must hold STALL_TIMEOUT itself on the cycle ERROR is entered.
  localparam int unsigned SCNT_W = $clog2(STALL_TIMEOUT + 1);

  if (PHASES_PER_INSTR != 4) begin : g_bad_phases
    $error("instr_phase_sequencer: PHASES_PER_INSTR must be 4");
  end
  if (STALL_TIMEOUT < 1) begin : g_bad_timeout
    $error("instr_phase_sequencer: STALL_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SCNT_W-1:0] stall_cnt;

  // Next-state decision; the last stalled EXEC cycle before the limit trips ERROR.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (halt_req)  state_nxt = S_HALTED;
        else if (run)  state_nxt = S_FETCH;
        else           state_nxt = S_IDLE;
      end
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (!stall)                                       state_nxt = S_WB;
        else if (stall_cnt == SCNT_W'(STALL_TIMEOUT - 1)) state_nxt = S_ERROR;
        else                                              state_nxt = S_EXEC;
      end
      S_WB: begin
        if (halt_req)  state_nxt = S_HALTED;
        else if (run)  state_nxt = S_FETCH;
        else           state_nxt = S_IDLE;
      end
      S_HALTED: state_nxt = resume ? S_IDLE : S_HALTED;
      S_ERROR:  state_nxt = resume ? S_IDLE : S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs (outputs follow the next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      stall_cnt     <= '0;
      retired_count <= '0;
      instr_done    <= 1'b0;
      ph_fetch      <= 1'b0;
      ph_decode     <= 1'b0;
      ph_exec       <= 1'b0;
      ph_wb         <= 1'b0;
      halted        <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      state <= state_nxt;

      // Only counts inside EXEC, so it is already zero on every EXEC entry.
      if (state != S_EXEC)  stall_cnt <= '0;
      else if (stall)       stall_cnt <= stall_cnt + SCNT_W'(1);

      instr_done <= (state == S_WB);
      if (state == S_WB) retired_count <= retired_count + CNT_W'(1);

      ph_fetch      <= (state_nxt == S_FETCH);
      ph_decode     <= (state_nxt == S_DECODE);
      ph_exec       <= (state_nxt == S_EXEC);
      ph_wb         <= (state_nxt == S_WB);
      halted        <= (state_nxt == S_HALTED);
      stall_timeout <= (state_nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Self-checking bench for instr_phase_sequencer: directed scenarios plus a
// randomized run compared cycle-by-cycle against a behavioural model.
module tb_instr_phase_sequencer;

  localparam int unsigned T_OUT = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n, run, halt_req, stall, resume;
  logic          ph_fetch, ph_decode, ph_exec, ph_wb;
  logic          instr_done, halted, stall_timeout;
  logic [CW-1:0] retired_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0=idle 1=running 2=halted 3=error; phase 0..3.
  int m_mode  = 0;
  int m_phase = 0;
  int m_stalls = 0;
  int m_ret   = 0;
  bit m_done  = 1'b0;

  instr_phase_sequencer #(
    .PHASES_PER_INSTR(4),
    .STALL_TIMEOUT(T_OUT),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .stall(stall), .resume(resume),
    .ph_fetch(ph_fetch), .ph_decode(ph_decode), .ph_exec(ph_exec), .ph_wb(ph_wb),
    .instr_done(instr_done), .retired_count(retired_count),
    .halted(halted), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_stalls = 0; m_ret = 0; m_done = 1'b0;
    end else begin
      m_done = (m_mode == 1 && m_phase == 3);
      if (m_done) m_ret = (m_ret + 1) % (1 << CW);
      case (m_mode)
        0: begin
          if (halt_req) m_mode = 2;
          else if (run) begin m_mode = 1; m_phase = 0; end
        end
        1: begin
          if (m_phase == 2) begin
            if (!stall) m_phase = 3;
            else begin
              m_stalls++;
              if (m_stalls >= T_OUT) m_mode = 3;
            end
          end else if (m_phase == 3) begin
            if (halt_req) m_mode = 2;
            else if (run) m_phase = 0;
            else m_mode = 0;
          end else begin
            m_phase++;
            if (m_phase == 2) m_stalls = 0;
          end
        end
        default: if (resume) m_mode = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; stall = 1'b0; resume = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ph_fetch, ph_decode, ph_exec, ph_wb, instr_done, halted, stall_timeout} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000000",
               {ph_fetch, ph_decode, ph_exec, ph_wb, instr_done, halted, stall_timeout});
    end
    checks++;
    if (retired_count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", retired_count);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    do_reset();
    run = 1'b1;
    cycle();
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (ph_fetch !== (i % 4 == 0 && i < 12)) begin
        failures++;
        $display("FAIL b2b_fetch cycle=%0d got=%b want=%b", i, ph_fetch, (i % 4 == 0 && i < 12));
      end
      checks++;
      if ($countones({ph_fetch, ph_decode, ph_exec, ph_wb}) !== ((i < 12) ? 1 : 0)) begin
        failures++;
        $display("FAIL b2b_onehot cycle=%0d got=%b", i, {ph_fetch, ph_decode, ph_exec, ph_wb});
      end
      if (instr_done) dones++;
      if (i == 8) run = 1'b0;
      if (i < 12) cycle();
    end
    checks++;
    if (dones != 3) begin
      failures++;
      $display("FAIL b2b_dones got=%0d want=3", dones);
    end
    checks++;
    if (retired_count !== CW'(3)) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=3", retired_count);
    end
  endtask

  task automatic test_stall();
    int execs = 0;
    int done_at = -1;
    do_reset();
    run = 1'b1;
    stall = 1'b1;
    cycle();
    run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ph_exec) execs++;
      if (instr_done && done_at < 0) done_at = i;
      stall = (execs < 6);
      checks++;
      if (stall_timeout !== 1'b0) begin
        failures++;
        $display("FAIL stall_no_timeout cycle=%0d got=%b want=0", i, stall_timeout);
      end
      cycle();
    end
    stall = 1'b0;
    checks++;
    if (execs != 6) begin
      failures++;
      $display("FAIL stall_exec_cycles got=%0d want=6", execs);
    end
    checks++;
    if (done_at != 9) begin
      failures++;
      $display("FAIL stall_done_latency got=%0d want=9", done_at);
    end
    checks++;
    if (retired_count !== CW'(1)) begin
      failures++;
      $display("FAIL stall_count got=%0d want=1", retired_count);
    end
  endtask

  task automatic test_timeout();
    int execs = 0;
    int err_at = -1;
    logic [CW-1:0] r0;
    r0 = retired_count;
    run = 1'b1;
    cycle();
    run = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 20 && err_at < 0; i++) begin
      if (ph_exec) execs++;
      if (stall_timeout) err_at = i;
      else cycle();
    end
    checks++;
    if (err_at != 10 || execs != 8) begin
      failures++;
      $display("FAIL timeout_entry at=%0d execs=%0d want at=10 execs=8", err_at, execs);
    end
    cycle(); cycle();
    checks++;
    if (stall_timeout !== 1'b1 || ph_exec !== 1'b0 || retired_count !== r0) begin
      failures++;
      $display("FAIL timeout_hold flag=%b exec=%b count=%0d want 1 0 %0d",
               stall_timeout, ph_exec, retired_count, r0);
    end
    stall = 1'b0;
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    checks++;
    if ({stall_timeout, ph_fetch, ph_decode, ph_exec, ph_wb, halted} !== 6'b0) begin
      failures++;
      $display("FAIL timeout_resume got=%b want=000000",
               {stall_timeout, ph_fetch, ph_decode, ph_exec, ph_wb, halted});
    end
  endtask

  task automatic test_halt();
    int fetches = 0;
    int halt_at = -1;
    do_reset();
    run = 1'b1;
    cycle();
    for (int i = 0; i < 20 && halt_at < 0; i++) begin
      if (ph_fetch) fetches++;
      if (ph_decode && fetches == 2) halt_req = 1'b1;
      if (halted) begin
        halt_at = i;
        checks++;
        if (instr_done !== 1'b1 || retired_count !== CW'(2)) begin
          failures++;
          $display("FAIL halt_count done=%b count=%0d want 1 2", instr_done, retired_count);
        end
      end else cycle();
    end
    checks++;
    if (halt_at != 8) begin
      failures++;
      $display("FAIL halt_entry at=%0d want=8", halt_at);
    end
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (halted !== 1'b1 || ph_fetch !== 1'b0) begin
        failures++;
        $display("FAIL halt_ignores_run halted=%b fetch=%b want 1 0", halted, ph_fetch);
      end
    end
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    checks++;
    if ({halted, ph_fetch, ph_decode, ph_exec, ph_wb} !== 5'b0) begin
      failures++;
      $display("FAIL halt_resume_idle got=%b want=00000", {halted, ph_fetch, ph_decode, ph_exec, ph_wb});
    end
    cycle();
    checks++;
    if (ph_fetch !== 1'b1) begin
      failures++;
      $display("FAIL halt_refetch got=%b want=1", ph_fetch);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    int guard = 0;
    do_reset();
    run = 1'b1;
    cycle();
    run = 1'b0;
    while (!instr_done && guard < 10) begin cycle(); guard++; end
    run = 1'b1;
    stall = 1'b1;
    while (!ph_exec && guard < 20) begin cycle(); guard++; end
    run = 1'b0;
    cycle(); cycle();
    checks++;
    if (ph_exec !== 1'b1 || retired_count !== CW'(1)) begin
      failures++;
      $display("FAIL rstmid_setup exec=%b count=%0d want 1 1", ph_exec, retired_count);
    end
    rst_n = 1'b0;
    cycle();
    checks++;
    if ({ph_fetch, ph_decode, ph_exec, ph_wb, instr_done, halted, stall_timeout} !== 7'b0
        || retired_count !== '0) begin
      failures++;
      $display("FAIL rstmid_clear flags=%b count=%0d want 0 0",
               {ph_fetch, ph_decode, ph_exec, ph_wb, instr_done, halted, stall_timeout}, retired_count);
    end
    rst_n = 1'b1;
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    int dones = 0;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 120 && dones < 16; i++) begin
      cycle();
      if (instr_done) begin
        dones++;
        checks++;
        if (retired_count !== CW'(dones % 16)) begin
          failures++;
          $display("FAIL wrap_count done=%0d got=%0d want=%0d", dones, retired_count, dones % 16);
        end
      end
    end
    checks++;
    if (dones != 16) begin
      failures++;
      $display("FAIL wrap_dones got=%0d want=16", dones);
    end
    run = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run      = ($urandom_range(0, 3) != 0);
      halt_req = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 2) != 0);
      resume   = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      cycle();
      want = {m_mode == 1 && m_phase == 0, m_mode == 1 && m_phase == 1,
              m_mode == 1 && m_phase == 2, m_mode == 1 && m_phase == 3,
              m_done, m_mode == 2, m_mode == 3};
      checks++;
      if ({ph_fetch, ph_decode, ph_exec, ph_wb, instr_done, halted, stall_timeout} !== want) begin
        failures++;
        $display("FAIL rand_flags cycle=%0d got=%b want=%b", i,
                 {ph_fetch, ph_decode, ph_exec, ph_wb, instr_done, halted, stall_timeout}, want);
      end
      checks++;
      if (retired_count !== CW'(m_ret)) begin
        failures++;
        $display("FAIL rand_count cycle=%0d got=%0d want=%0d", i, retired_count, m_ret);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; stall = 1'b0; resume = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_halt();
    test_reset_mid_exec();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
